vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter CLK_DIV, default 2, clk cycles per pixel; legal range is 2 to 16.
REQ-006 SHALL have parameters HS_POL / VS_POL, default 0 / 0, sync level during the sync pulse.
REQ-007 SHALL have parameter CW, default 16, counter width; COLOR_W, default 8, width of each colour channel.
REQ-008 SHALL have ports: clk input 1, system clock.
REQ-009 SHALL have ports: reset input 1, synchronous, active-high.
REQ-010 SHALL have ports: v_enable input 1, run/hold control.
REQ-011 SHALL have ports: pix_r / pix_g / pix_b input COLOR_W each, pixel data from the source, sampled on pixel_ce.
REQ-012 SHALL have ports: pixel_ce output 1, one-clk pixel strobe.
REQ-013 SHALL have ports: clkVGA output 1, divided pixel clock for the DAC.
REQ-014 SHALL have ports: horiz_count / vert_count output CW each, current pixel coordinates.
REQ-015 SHALL have ports: frame_start output 1, one-clk pulse at pixel (0,0).
REQ-016 SHALL have ports: R / G / B output COLOR_W each, colour outputs.
REQ-017 SHALL have ports: horiz_sync / vert_sync output 1, sync outputs.
REQ-018 SHALL have ports: vga_blank output 1, active-low blank.
REQ-019 SHALL have ports: vga_sync output 1, DAC composite sync, tied to 0.

Function
REQ-020 SHALL hold a divider counter div that runs 0..CLK_DIV-1 and wraps.
REQ-021 pixel_ce SHALL be 1 exactly when div==CLK_DIV-1 and v_enable==1.
REQ-022 clkVGA SHALL be 1 when div>=CLK_DIV/2 (integer division) and 0 otherwise.
REQ-023 On each pixel_ce, horiz_count SHALL increment; at the wrap point horiz_count==HT-1 (HT = H_ACTIVE+H_FP+H_SYNC+H_BP) it SHALL return to 0 and vert_count SHALL advance.
REQ-024 vert_count SHALL wrap to 0 after VT-1 (VT = V_ACTIVE+V_FP+V_SYNC+V_BP).
REQ-025 frame_start SHALL pulse for the single clk in which pixel_ce==1 and both counters wrap to 0.
REQ-026 The display-side outputs (horiz_sync, vert_sync, vga_blank, R/G/B) SHALL be registered on pixel_ce from the pre-increment counter values, one pixel behind horiz_count/vert_count.
REQ-027 horiz_sync SHALL equal HS_POL while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, and ~HS_POL otherwise.
REQ-028 vert_sync SHALL follow the same rule as REQ-027 using the vertical counter, V_* parameters and VS_POL.
REQ-029 vga_blank SHALL be 1 only when h<H_ACTIVE and v<V_ACTIVE.
REQ-030 R/G/B SHALL equal pix_* when vga_blank==1, and 0 otherwise.
REQ-031 While v_enable==0: div, both counters and all registered outputs SHALL hold their values; pixel_ce and frame_start SHALL be 0.
REQ-032 When v_enable returns to 1, counting SHALL resume from the held values with no skipped pixel.
REQ-033 Counter arithmetic SHALL be unsigned CW-bit; when CW is too narrow for HT-1 or VT-1, elaboration SHALL fail.

Reset
REQ-034 On reset==1 at a clk edge, the following SHALL go to 0: div, horiz_count, vert_count, pixel_ce, frame_start, R/G/B, vga_blank, clkVGA.
REQ-035 On reset, horiz_sync SHALL go to ~HS_POL and vert_sync to ~VS_POL.
REQ-036 Reset SHALL take priority over v_enable, including when asserted mid-line or mid-frame.
REQ-037 The first pixel_ce after reset release SHALL occur CLK_DIV clks later.

Configuration
REQ-038 With macro VGA_TEST_PATTERN_EN defined, the block SHALL add input pattern_sel (1 bit); when pattern_sel==1, colour SHALL come from 8 internal vertical bars instead of pix_*.
REQ-039 Each bar SHALL be H_ACTIVE/8 pixels wide; bar index k (0..7) SHALL drive R={COLOR_W{k[2]}}, G={COLOR_W{k[1]}}, B={COLOR_W{k[0]}}.
REQ-040 Bar colours SHALL be blanked exactly as in REQ-030.
REQ-041 Without VGA_TEST_PATTERN_EN, the pattern_sel port and bar logic SHALL be absent, and colour SHALL always come from pix_*.

Verification (small parameters: H 8/2/3/3 -> HT=16, V 4/1/2/1 -> VT=8, CLK_DIV=2, HS_POL=VS_POL=0)
REQ-042 Free-run from reset -> pixel_ce every 2nd clk; horiz_count runs 0..15; frame_start pulses every 256 clks.
REQ-043 Sync timing -> horiz_sync==0 for display columns 10..12 (3 pixels); vert_sync==0 for lines 5..6; vga_blank==0 in every non-visible pixel.
REQ-044 pix_r=8'hA5 held constant -> R==8'hA5 in visible pixels, 0 in blanking, lagging horiz_count by one pixel.
REQ-045 v_enable=0 at h=5, v=2 for 10 clks -> counters frozen and no pixel_ce; after re-enable, the next value is h=6.
REQ-046 reset asserted at h=9, v=6 -> next clk all outputs at reset values (horiz_sync=1, vert_sync=1).
REQ-047 VGA_TEST_PATTERN_EN defined, pattern_sel=1 -> column 7 gives R=G=B=8'hFF; column 0 gives all 0.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides clk into a pixel strobe, runs h/v
// counters and produces registered syncs, blank and colour.
// Parameters:
//   H_ACTIVE/H_FP/H_SYNC/H_BP and V_ACTIVE/V_FP/V_SYNC/V_BP set the raster.
//   CLK_DIV is clk cycles per pixel (2..16).
//   HS_POL/VS_POL are the sync levels.
//   CW is the counter width and COLOR_W the channel width.
// Ports:
//   clk, reset (sync, active-high), v_enable (run/hold)
//   pix_r/g/b     : source colour, sampled on pixel_ce
//   pixel_ce      : one-clk pixel strobe
//   clkVGA        : divided pixel clock for the DAC
//   horiz_count, vert_count : current coordinates
//   frame_start   : one-clk pulse when both counters wrap
//   R/G/B, horiz_sync, vert_sync, vga_blank : registered, one pixel late
//   vga_sync      : DAC composite sync, constant 0
// Optional: define VGA_TEST_PATTERN_EN to add pattern_sel, which selects
// eight internal colour bars instead of pix_r/g/b.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 16,
   parameter int COLOR_W  = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               v_enable,
   input  logic [COLOR_W-1:0] pix_r,
   input  logic [COLOR_W-1:0] pix_g,
   input  logic [COLOR_W-1:0] pix_b,
`ifdef VGA_TEST_PATTERN_EN
   input  logic               pattern_sel,
`endif
   output logic               pixel_ce,
   output logic               clkVGA,
   output logic [CW-1:0]      horiz_count,
   output logic [CW-1:0]      vert_count,
   output logic               frame_start,
   output logic [COLOR_W-1:0] R,
   output logic [COLOR_W-1:0] G,
   output logic [COLOR_W-1:0] B,
   output logic               horiz_sync,
   output logic               vert_sync,
   output logic               vga_blank,
   output logic               vga_sync
);

   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW = 5;

   // Compares are done one bit wider than the counters so that a sync
   // edge landing exactly on HT/VT cannot alias to zero.
   localparam logic [CW:0] H_VIS  = (CW+1)'(H_ACTIVE);
   localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
   localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW:0] V_VIS  = (CW+1)'(V_ACTIVE);
   localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
   localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic [CW-1:0] H_LAST = CW'(HT - 1);
   localparam logic [CW-1:0] V_LAST = CW'(VT - 1);

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);

   if (((HT - 1) >> CW) != 0 || ((VT - 1) >> CW) != 0) begin : g_cw_chk
      $error("vga_timing_gen: CW too narrow for HT-1 or VT-1");
   end

   if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_div_chk
      $error("vga_timing_gen: CLK_DIV outside 2..16");
   end

   logic [DW-1:0]      div_q, div_d;
   logic [CW-1:0]      h_q, h_d;
   logic [CW-1:0]      v_q, v_d;
   logic               hs_q, hs_d;
   logic               vs_q, vs_d;
   logic               blank_q, blank_d;
   logic [COLOR_W-1:0] r_q, r_d;
   logic [COLOR_W-1:0] g_q, g_d;
   logic [COLOR_W-1:0] b_q, b_d;

   logic               ce;
   logic [CW:0]        hx, vx;
   logic [COLOR_W-1:0] src_r, src_g, src_b;

`ifdef VGA_TEST_PATTERN_EN
   localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   logic [2:0] bar_k;
`endif

   always_comb begin
      ce      = v_enable && (div_q == DIV_LAST);
      hx      = {1'b0, h_q};
      vx      = {1'b0, v_q};
      div_d   = div_q;
      h_d     = h_q;
      v_d     = v_q;
      src_r   = pix_r;
      src_g   = pix_g;
      src_b   = pix_b;
`ifdef VGA_TEST_PATTERN_EN
      bar_k   = 3'(h_q / CW'(BAR_W));
      if (pattern_sel) begin
         src_r = {COLOR_W{bar_k[2]}};
         src_g = {COLOR_W{bar_k[1]}};
         src_b = {COLOR_W{bar_k[0]}};
      end
`endif
      if (v_enable) begin
         div_d = ce ? '0 : div_q + DW'(1);
      end
      if (ce) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
         end else begin
            h_d = h_q + CW'(1);
         end
      end
      // Display side is computed from the pre-increment coordinates.
      hs_d    = (hx >= HS_BEG && hx < HS_END) ? HS_POL : ~HS_POL;
      vs_d    = (vx >= VS_BEG && vx < VS_END) ? VS_POL : ~VS_POL;
      blank_d = (hx < H_VIS) && (vx < V_VIS);
      r_d     = blank_d ? src_r : '0;
      g_d     = blank_d ? src_g : '0;
      b_d     = blank_d ? src_b : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         hs_q    <= ~HS_POL;
         vs_q    <= ~VS_POL;
         blank_q <= 1'b0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
         if (ce) begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
         end
      end
   end

   assign pixel_ce    = ce;
   assign clkVGA      = (div_q >= DIV_HALF);
   assign frame_start = ce && (h_q == H_LAST) && (v_q == V_LAST);
   assign horiz_count = h_q;
   assign vert_count  = v_q;
   assign horiz_sync  = hs_q;
   assign vert_sync   = vs_q;
   assign vga_blank   = blank_q;
   assign R           = r_q;
   assign G           = g_q;
   assign B           = b_q;
   assign vga_sync    = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a small raster (HT=16, VT=8, CLK_DIV=2).
// Table phases, hand sequences and random stimulus against a pixel-index model.
module tb_vga_timing_gen;

   localparam int HA = 8, HF = 2, HS = 3, HB = 3;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int CD = 2, CW = 8;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic [7:0] pr  = 8'h00, pg = 8'h00, pb = 8'h00;
   logic       psel = 1'b0;
   logic       ce, cvga, fs, hsy, vsy, blk, csy;
   logic [CW-1:0] hc, vc;
   logic [7:0] ro, go, bo;

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CLK_DIV(CD), .HS_POL(1'b0), .VS_POL(1'b0),
      .CW(CW), .COLOR_W(8)
   ) dut (
      .clk(clk), .reset(rst), .v_enable(en),
      .pix_r(pr), .pix_g(pg), .pix_b(pb),
`ifdef VGA_TEST_PATTERN_EN
      .pattern_sel(psel),
`endif
      .pixel_ce(ce), .clkVGA(cvga),
      .horiz_count(hc), .vert_count(vc),
      .frame_start(fs), .R(ro), .G(go), .B(bo),
      .horiz_sync(hsy), .vert_sync(vsy),
      .vga_blank(blk), .vga_sync(csy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: ticks = enabled clks since reset; pixel index = ticks / CD.
   int   ticks = 0;
   bit   m_hs = 1'b1, m_vs = 1'b1, m_bl = 1'b0;
   logic [7:0] m_r = 8'h00, m_g = 8'h00, m_b = 8'h00;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic mdl_edge();
      int n, h, v, k;
      if (rst) begin
         ticks = 0;
         m_hs = 1'b1; m_vs = 1'b1; m_bl = 1'b0;
         m_r = 8'h00; m_g = 8'h00; m_b = 8'h00;
      end else if (en) begin
         if (ticks % CD == CD - 1) begin
            n = ticks / CD;
            h = n % HT;
            v = (n / HT) % VT;
            m_hs = !(h >= HA + HF && h < HA + HF + HS);
            m_vs = !(v >= VA + VF && v < VA + VF + VS);
            m_bl = (h < HA) && (v < VA);
            m_r = pr; m_g = pg; m_b = pb;
            if (psel) begin
               k = (h / (HA / 8)) % 8;
               m_r = (k & 4) != 0 ? 8'hFF : 8'h00;
               m_g = (k & 2) != 0 ? 8'hFF : 8'h00;
               m_b = (k & 1) != 0 ? 8'hFF : 8'h00;
            end
            if (!m_bl) begin
               m_r = 8'h00; m_g = 8'h00; m_b = 8'h00;
            end
         end
         ticks++;
      end
   endtask

   task automatic cyc();
      int n, d;
      bit e_ce;
      @(posedge clk);
      mdl_edge();
      #1;
      n    = ticks / CD;
      d    = ticks % CD;
      e_ce = en && (d == CD - 1);
      chk("m_h", 32'(hc), 32'(n % HT));
      chk("m_v", 32'(vc), 32'((n / HT) % VT));
      chk("m_ce", 32'(ce), 32'(e_ce));
      chk("m_clkvga", 32'(cvga), 32'(d >= CD / 2));
      chk("m_fs", 32'(fs),
          32'(e_ce && n % HT == HT - 1 && (n / HT) % VT == VT - 1));
      chk("m_hs", 32'(hsy), 32'(m_hs));
      chk("m_vs", 32'(vsy), 32'(m_vs));
      chk("m_blank", 32'(blk), 32'(m_bl));
      chk("m_rgb", {8'h00, ro, go, bo}, {8'h00, m_r, m_g, m_b});
      chk("m_csync", 32'(csy), 32'd0);
   endtask

   typedef struct {
      bit r; bit e; int n;
      int h; int v; bit hs; bit vs; bit bl; int red;
   } vec_t;

   vec_t tbl[10];
   int   seen, cnt, last, gap;

   initial begin
      tbl[0] = '{1, 1,   4,  0, 0, 1, 1, 0, 8'h00};
      tbl[1] = '{0, 1,   2,  1, 0, 1, 1, 1, 8'hA5};
      tbl[2] = '{0, 1,  18, 10, 0, 1, 1, 0, 8'h00};
      tbl[3] = '{0, 1,   2, 11, 0, 0, 1, 0, 8'h00};
      tbl[4] = '{0, 1,   6, 14, 0, 1, 1, 0, 8'h00};
      tbl[5] = '{0, 1,  10,  3, 1, 1, 1, 1, 8'hA5};
      tbl[6] = '{0, 0,  10,  3, 1, 1, 1, 1, 8'hA5};
      tbl[7] = '{0, 1,   2,  4, 1, 1, 1, 1, 8'hA5};
      tbl[8] = '{0, 1, 128,  4, 5, 1, 0, 0, 8'h00};
      tbl[9] = '{1, 1,   1,  0, 0, 1, 1, 0, 8'h00};

      pr = 8'hA5; pg = 8'h3C; pb = 8'h0F;
      for (int i = 0; i < 10; i++) begin
         rst = tbl[i].r;
         en  = tbl[i].e;
         for (int c = 0; c < tbl[i].n; c++) cyc();
         chk("tbl_h", 32'(hc), 32'(tbl[i].h));
         chk("tbl_v", 32'(vc), 32'(tbl[i].v));
         chk("tbl_hs", 32'(hsy), 32'(tbl[i].hs));
         chk("tbl_vs", 32'(vsy), 32'(tbl[i].vs));
         chk("tbl_blank", 32'(blk), 32'(tbl[i].bl));
         chk("tbl_r", 32'(ro), 32'(tbl[i].red));
      end

      // Hold at h=5, v=2, then resume with no skipped pixel.
      rst = 1'b0; en = 1'b1;
      for (int c = 0; c < 74; c++) cyc();
      chk("hold_pre_h", 32'(hc), 32'd5);
      chk("hold_pre_v", 32'(vc), 32'd2);
      en = 1'b0; seen = 0;
      for (int c = 0; c < 10; c++) begin
         cyc();
         if (ce) seen++;
      end
      chk("hold_ce", 32'(seen), 32'd0);
      chk("hold_h", 32'(hc), 32'd5);
      chk("hold_v", 32'(vc), 32'd2);
      en = 1'b1; seen = 0;
      for (int c = 0; c < 4 && !seen; c++) begin
         cyc();
         if (ce) seen = 1;
      end
      chk("resume_ce_seen", 32'(seen), 32'd1);
      cyc();
      chk("resume_h", 32'(hc), 32'd6);

      // Reset mid-frame at h=9, v=6.
      rst = 1'b1; cyc();
      rst = 1'b0;
      for (int c = 0; c < 210; c++) cyc();
      chk("mid_h", 32'(hc), 32'd9);
      chk("mid_v", 32'(vc), 32'd6);
      rst = 1'b1; cyc();
      chk("rst_h", 32'(hc), 32'd0);
      chk("rst_v", 32'(vc), 32'd0);
      chk("rst_hs", 32'(hsy), 32'd1);
      chk("rst_vs", 32'(vsy), 32'd1);
      chk("rst_blank", 32'(blk), 32'd0);
      chk("rst_rgb", {8'h00, ro, go, bo}, 32'd0);
      chk("rst_ce", 32'(ce), 32'd0);
      chk("rst_clkvga", 32'(cvga), 32'd0);

      // frame_start period from reset release.
      rst = 1'b0; cnt = 0; last = -1; gap = 0;
      for (int c = 0; c < 600; c++) begin
         cyc();
         if (fs) begin
            if (last >= 0) gap = c - last;
            last = c;
            cnt++;
         end
      end
      chk("fs_count", 32'(cnt), 32'd2);
      chk("fs_period", 32'(gap), 32'd256);

`ifdef VGA_TEST_PATTERN_EN
      psel = 1'b1; rst = 1'b1; cyc();
      rst = 1'b0;
      for (int c = 0; c < 2; c++) cyc();
      chk("bar0_rgb", {8'h00, ro, go, bo}, 32'd0);
      for (int c = 0; c < 14; c++) cyc();
      chk("bar7_rgb", {8'h00, ro, go, bo}, 32'h00FFFFFF);
      psel = 1'b0;
`endif

      // Random inputs, occasional reset and hold.
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         en  = ($urandom_range(0, 7) != 0);
         pr  = 8'($urandom);
         pg  = 8'($urandom);
         pb  = 8'($urandom);
`ifdef VGA_TEST_PATTERN_EN
         psel = ($urandom_range(0, 3) == 0);
`endif
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
